// File: rtl/and_gate_bist.sv
// Self-test controller for a two-input AND gate.
// Steps the gate inputs through {A,B} = 00, 01, 10, 11. Each vector is held
// for SETTLE_CYCLES cycles, and Y is sampled at the end of one further CHECK
// cycle. The run reports a pass flag, a saturating mismatch count and the
// first failing vector.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             level-sampled run request, accepted in idle or done
//   invert_exp_i        invert the expected Y; latched when start is accepted
//   dut_a_o, dut_b_o    registered stimulus to the gate under test
//   dut_y_i             gate output; X or Z counts as a mismatch
//   busy_o, done_o      run in progress / results valid until the next start
//   pass_o              done with zero mismatches
//   fail_cnt_o          mismatching vectors in the last run, saturating
//   first_fail_valid_o  at least one mismatch in the last run
//   first_fail_vec_o    {A,B} of the first mismatching vector
module and_gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             invert_exp_i,
  output logic             dut_a_o,
  output logic             dut_b_o,
  input  logic             dut_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             first_fail_valid_o,
  output logic [1:0]       first_fail_vec_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0]       SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  // The vector index doubles as the registered stimulus. It is 00 whenever
  // the engine is idle or done.
  logic [1:0]       vec_q, vec_d;
  logic             inv_q, inv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ffvec_q, ffvec_d;
  logic             exp_y;
  logic             mismatch;

  assign exp_y    = (vec_q[1] & vec_q[0]) ^ inv_q;
  // Case inequality, so an undriven or unknown Y is reported as a failure.
  assign mismatch = (dut_y_i !== exp_y);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    vec_d      = vec_q;
    inv_d      = inv_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StSettle;
          settle_d   = 4'd0;
          vec_d      = 2'b00;
          inv_d      = invert_exp_i;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_cnt_d = '0;
          ffv_d      = 1'b0;
          ffvec_d    = 2'b00;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + CntOne;
          end
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        settle_d = 4'd0;
        // After 11 the index wraps to 00, which is also the drive value in done.
        vec_d    = vec_q + 2'd1;
        if (vec_q == 2'b11) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the next count, so the last vector's mismatch is included.
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= 4'd0;
      vec_q      <= 2'b00;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      vec_q      <= vec_d;
      inv_q      <= inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      ffv_q      <= ffv_d;
      ffvec_q    <= ffvec_d;
    end
  end

  assign dut_a_o            = vec_q[1];
  assign dut_b_o            = vec_q[0];
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign fail_cnt_o         = fail_cnt_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_vec_o   = ffvec_q;

endmodule

// File: doc/and_gate_bist.md
# and_gate_bist

Hardware self-test controller for a two-input AND gate. It drives the gate's A/B inputs through all four input combinations, waits a programmable settle time, and samples Y against the expected value. It reports pass/fail, a mismatch count and the first failing vector. It sits beside a gate-under-test instance and replaces simulation-only stimulus with a synthesizable start/busy/done engine usable on silicon or FPGA.

## Interface
- SETTLE_CYCLES, default 1: cycles each vector is held before Y is sampled. Legal values are 1..15.
- CNT_W, default 3: width of fail_cnt. Minimum is 3.
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a test run; accepted only in IDLE or DONE
- invert_exp  input  1  invert expected Y (negative self-test); latched when start is accepted
- dut_a  output  1  A input to gate under test
- dut_b  output  1  B input to gate under test
- dut_y  input  1  Y output from gate under test
- busy  output  1  run in progress
- done  output  1  run complete; results valid; held until next accepted start
- pass  output  1  1 when done and fail_cnt==0
- fail_cnt  output  CNT_W  number of mismatching vectors in last run
- first_fail_valid  output  1  at least one mismatch in last run
- first_fail_vec  output  2  {A,B} of first mismatching vector

## Operation
- Reset values, applied asynchronously on rst_n low: state=IDLE, dut_a=dut_b=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_valid=0, first_fail_vec=2'b00, latched invert=0.
- States:
  - IDLE: start moves to SETTLE.
  - SETTLE: hold the current vector.
  - CHECK: sample dut_y, then go to SETTLE for the next vector or to DONE after the last vector.
  - DONE: start moves to SETTLE and begins a new run.
- Vector order is fixed: {A,B} = 00, 01, 10, 11, driven from a 2-bit index.
- Expected value: exp = (A & B) ^ inv_latched.
- Mismatch rule: dut_y !== exp, so X or Z on dut_y counts as a failure.
- On a mismatch:
  - fail_cnt increments, saturating at all-ones.
  - If first_fail_valid is 0, capture {A,B} into first_fail_vec and set first_fail_valid.
- Accepting start:
  - clears fail_cnt, first_fail_valid, first_fail_vec, done and pass;
  - sets busy;
  - latches invert_exp;
  - loads vector index 0.
- start during busy is ignored; the run is not restarted.
- In IDLE and DONE, dut_a and dut_b are 0.
- A reset mid-run aborts the run. All outputs return to their reset values with no partial result retained.

## Timing
- start is sampled at rising edge E0. From E0+ onward: busy=1 and {dut_a,dut_b}=00.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in SETTLE, then 1 cycle in CHECK.
- dut_y is sampled at the rising edge that ends the CHECK cycle. The next vector is driven from that same edge.
- busy stays high for exactly 4*(SETTLE_CYCLES+1) cycles. For SETTLE_CYCLES=1 that is 8 cycles.
- On the edge that ends the last CHECK cycle:
  - busy falls and done rises;
  - pass, fail_cnt and first_fail_* are final;
  - the final mismatch is already included in these results.
- dut_a and dut_b are registered outputs and glitch-free.
- dut_y is assumed combinational from dut_a/dut_b and settled within SETTLE_CYCLES cycles.
- start is treated as a level sample, not an edge. If start is held high in DONE, the next run begins on the following edge.
- Ordering between done and fail_cnt: fail_cnt is never read as valid before done=1.

## Test plan
- Correct AND gate, invert_exp=0, SETTLE_CYCLES=1, 1-cycle start pulse:
  - busy is high for 8 cycles, vectors appear in order 00, 01, 10, 11;
  - then done=1, pass=1, fail_cnt=0, first_fail_valid=0.
- Correct AND gate, invert_exp=1:
  - fail_cnt=4, pass=0, first_fail_valid=1, first_fail_vec=00.
- Gate stuck-at-0 on Y:
  - fail_cnt=1, first_fail_vec=11.
- Gate stuck-at-1 on Y:
  - fail_cnt=3, first_fail_vec=00.
- Start with a correct gate, pulse start again at busy cycle 3, then deassert rst_n at busy cycle 5:
  - the second start has no effect;
  - the reset returns all outputs to reset values immediately, asynchronously;
  - a later start completes normally with pass=1.
- SETTLE_CYCLES=3, correct gate:
  - each vector is held for 4 cycles and busy lasts 16 cycles;
  - dut_y driven X during the first 2 cycles of each vector still gives pass=1.
